// File: rtl/div_pkg.sv
// Shared definitions for the sequential 16/8 restoring divider.
// Holds the FSM state type, default widths and the iteration counter width.
package div_pkg;

    localparam int N_W_DEF = 16;
    localparam int D_W_DEF = 8;
    localparam int CNT_W   = $clog2(N_W_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step (purely combinational).
// Ports:
//   rem      - partial remainder entering the step (D_W+1 bits, value < divisor)
//   bit_in   - next dividend bit shifted into the remainder
//   divisor  - unsigned divisor
//   rem_next - partial remainder after the conditional subtract
//   q_bit    - resolved quotient bit
module div_step #(
    parameter int D_W = 8
) (
    input  logic [D_W:0]   rem,
    input  logic           bit_in,
    input  logic [D_W-1:0] divisor,
    output logic [D_W:0]   rem_next,
    output logic           q_bit
);

    logic [D_W:0] t;
    logic [D_W:0] diff;
    logic         unused_rem_msb;

    // The incoming remainder is always below the divisor, so its top bit is
    // zero and only the low D_W bits take part in the shift.
    assign unused_rem_msb = rem[D_W];

    assign t        = {rem[D_W-1:0], bit_in};
    assign diff     = t - {1'b0, divisor};
    assign q_bit    = (t >= {1'b0, divisor});
    assign rem_next = q_bit ? diff : t;

endmodule

// File: rtl/seq_divider_16by8.sv
// Sequential radix-2 restoring divider, N_W-bit dividend by D_W-bit divisor.
// One quotient bit is resolved per clock; valid/ready on input and output.
// Ports:
//   clk, rst_n             - clock, asynchronous active-low reset
//   in_valid / in_ready    - operand handshake (in_ready high only in IDLE)
//   dividend, divisor      - unsigned operands, captured on accept
//   out_valid / out_ready  - result handshake
//   quotient, remainder    - registered result, stable while out_valid
//   div_by_zero            - set when the captured divisor was zero
module seq_divider_16by8
    import div_pkg::*;
#(
    parameter int N_W = N_W_DEF,
    parameter int D_W = D_W_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N_W-1:0] dividend,
    input  logic [D_W-1:0] divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N_W-1:0] quotient,
    output logic [D_W-1:0] remainder,
    output logic           div_by_zero
);

    localparam int CNT_BITS = $clog2(N_W);

    state_t              state;
    // quo starts as the dividend; each step shifts a dividend bit out of the
    // MSB and a quotient bit into the LSB, so it ends holding the quotient.
    logic [N_W-1:0]      quo;
    logic [D_W:0]        rem;
    logic [D_W-1:0]      dvs;
    logic [CNT_BITS-1:0] cnt;
    logic                dbz;
    logic [D_W:0]        rem_next;
    logic                q_bit;

    div_step #(.D_W(D_W)) u_step (
        .rem      (rem),
        .bit_in   (quo[N_W-1]),
        .divisor  (dvs),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    assign in_ready    = (state == IDLE);
    assign quotient    = quo;
    assign remainder   = rem[D_W-1:0];
    assign div_by_zero = dbz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            quo       <= '0;
            rem       <= '0;
            dvs       <= '0;
            cnt       <= '0;
            dbz       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        dvs <= divisor;
                        if (divisor == '0) begin
                            // Zero divisor short-circuits straight to a result.
                            quo       <= '1;
                            rem       <= {1'b0, dividend[D_W-1:0]};
                            dbz       <= 1'b1;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            quo   <= dividend;
                            rem   <= '0;
                            dbz   <= 1'b0;
                            cnt   <= CNT_BITS'(N_W - 1);
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    quo <= {quo[N_W-2:0], q_bit};
                    rem <= rem_next;
                    if (cnt == '0) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt - CNT_BITS'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider_16by8.sv
// Self-checking bench for seq_divider_16by8: directed vector table, hand-written
// corner sequences (hold-off, mid-op reset) and randomized operations checked
// against plain arithmetic division.
module tb_seq_divider_16by8;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;

    seq_divider_16by8 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] n;
        logic [7:0]  d;
        logic [15:0] q;
        logic [7:0]  r;
        logic        z;
        int          stall;
        bit          early;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer division, all-ones quotient on a zero divisor.
    task automatic model(input logic [15:0] n, input logic [7:0] d,
                         output logic [15:0] q, output logic [7:0] r, output logic z);
        if (d == 0) begin
            q = 16'hFFFF;
            r = n[7:0];
            z = 1'b1;
        end else begin
            q = n / 16'(d);
            r = 8'(n % 16'(d));
            z = 1'b0;
        end
    endtask

    // Runs one operation. Inputs are driven and outputs sampled on negedges.
    // hold_next keeps in_valid high with the next operands through the stall
    // and hand-off, so the block must ignore them until it is back in IDLE.
    task automatic run_op(input logic [15:0] n, input logic [7:0] d,
                          input logic [15:0] eq, input logic [7:0] er, input logic ez,
                          input int stall, input bit early,
                          input bit hold_next, input logic [15:0] nn, input logic [7:0] nd,
                          input string tag,
                          output logic [15:0] aq, output logic [7:0] ar);
        int  w;
        int  lat;
        bit  rdy_low;
        bit  stable;
        w = 0;
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk({tag, " in_ready before accept"}, 32'(in_ready), 32'd1);
        dividend  = n;
        divisor   = d;
        in_valid  = 1'b1;
        out_ready = early;
        @(posedge clk);
        @(negedge clk);
        lat     = 1;
        rdy_low = 1'b1;
        // Operands and in_valid are scrambled while busy; neither may matter.
        while (!out_valid && lat < 100) begin
            if (in_ready) rdy_low = 1'b0;
            in_valid = 1'($urandom);
            dividend = 16'($urandom);
            divisor  = 8'($urandom);
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), (d == 0) ? 32'd1 : 32'd17);
        chk({tag, " in_ready low while busy"}, 32'(rdy_low && !in_ready), 32'd1);
        aq = quotient;
        ar = remainder;
        chk({tag, " quotient"}, 32'(quotient), 32'(eq));
        chk({tag, " remainder"}, 32'(remainder), 32'(er));
        chk({tag, " div_by_zero"}, 32'(div_by_zero), 32'(ez));
        if (early) begin
            in_valid = 1'b0;
            @(negedge clk);
            chk({tag, " out_valid single pulse"}, 32'(out_valid), 32'd0);
            chk({tag, " in_ready after hand-off"}, 32'(in_ready), 32'd1);
            out_ready = 1'b0;
        end else begin
            stable = 1'b1;
            for (int i = 0; i < stall; i++) begin
                if (hold_next) begin
                    in_valid = 1'b1;
                    dividend = nn;
                    divisor  = nd;
                end else begin
                    in_valid = 1'($urandom);
                    dividend = 16'($urandom);
                    divisor  = 8'($urandom);
                end
                @(negedge clk);
                if (!out_valid || quotient !== eq || remainder !== er ||
                    div_by_zero !== ez || in_ready)
                    stable = 1'b0;
            end
            chk({tag, " result held during stall"}, 32'(stable), 32'd1);
            in_valid = hold_next;
            if (hold_next) begin
                dividend = nn;
                divisor  = nd;
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            chk({tag, " out_valid dropped"}, 32'(out_valid), 32'd0);
            if (!hold_next) in_valid = 1'b0;
        end
    endtask

    vec_t        vecs[$];
    logic [15:0] aq, eq, rn;
    logic [7:0]  ar, er, rd;
    logic        ez;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;

        vecs.push_back('{16'd1000,  8'd7,    16'd142,    8'd6,    1'b0, 0, 1'b1});
        vecs.push_back('{16'hFFFF,  8'hFF,   16'h0101,   8'h00,   1'b0, 0, 1'b1});
        vecs.push_back('{16'hFFFF,  8'h01,   16'hFFFF,   8'h00,   1'b0, 0, 1'b1});
        vecs.push_back('{16'h0005,  8'h00,   16'hFFFF,   8'h05,   1'b1, 2, 1'b0});
        vecs.push_back('{16'h00FF,  8'h00,   16'hFFFF,   8'hFF,   1'b1, 0, 1'b1});
        vecs.push_back('{16'd7,     8'd8,    16'd0,      8'd7,    1'b0, 1, 1'b0});
        vecs.push_back('{16'h0000,  8'h01,   16'h0000,   8'h00,   1'b0, 0, 1'b0});
        vecs.push_back('{16'hABCD,  8'h01,   16'hABCD,   8'h00,   1'b0, 3, 1'b0});
        vecs.push_back('{16'd255,   8'd255,  16'd1,      8'd0,    1'b0, 0, 1'b1});
        vecs.push_back('{16'hFFFF,  8'h80,   16'h01FF,   8'h7F,   1'b0, 0, 1'b0});
        vecs.push_back('{16'h8000,  8'h03,   16'h2AAA,   8'h02,   1'b0, 1, 1'b0});

        repeat (3) @(negedge clk);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset quotient", 32'(quotient), 32'd0);
        chk("reset remainder", 32'(remainder), 32'd0);
        chk("reset div_by_zero", 32'(div_by_zero), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready after reset", 32'(in_ready), 32'd1);

        foreach (vecs[i])
            run_op(vecs[i].n, vecs[i].d, vecs[i].q, vecs[i].r, vecs[i].z,
                   vecs[i].stall, vecs[i].early, 1'b0, '0, '0,
                   $sformatf("vec%0d", i), aq, ar);

        // Result held 10 cycles while the next operation waits on in_valid.
        run_op(16'd100, 8'd200, 16'd0, 8'd100, 1'b0, 10, 1'b0,
               1'b1, 16'h1234, 8'h10, "hold 100/200", aq, ar);
        run_op(16'h1234, 8'h10, 16'h0123, 8'h04, 1'b0, 0, 1'b0,
               1'b0, '0, '0, "after hold 1234/10", aq, ar);

        // Reset during BUSY cycle 8 of 1000/7.
        @(negedge clk);
        dividend = 16'd1000;
        divisor  = 8'd7;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid-op reset out_valid", 32'(out_valid), 32'd0);
        chk("mid-op reset quotient", 32'(quotient), 32'd0);
        chk("mid-op reset remainder", 32'(remainder), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready after mid-op reset", 32'(in_ready), 32'd1);
        chk("out_valid after mid-op reset", 32'(out_valid), 32'd0);
        run_op(16'h1234, 8'h10, 16'h0123, 8'h04, 1'b0, 0, 1'b0,
               1'b0, '0, '0, "post-reset 1234/10", aq, ar);

        // Randomized operations with random stalls.
        for (int k = 0; k < 2000; k++) begin
            rn = 16'($urandom);
            case ($urandom_range(0, 7))
                0:       rd = 8'd0;
                1:       rd = 8'($urandom_range(1, 4));
                default: rd = 8'($urandom);
            endcase
            model(rn, rd, eq, er, ez);
            run_op(rn, rd, eq, er, ez, $urandom_range(0, 2), 1'($urandom),
                   1'b0, '0, '0, "rand", aq, ar);
            if (rd != 0) begin
                chk("rand q*d+r==n", 32'(aq) * 32'(rd) + 32'(ar), 32'(rn));
                chk("rand r<d", 32'(ar < rd), 32'd1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_divider_16by8.md
Name: seq_divider_16by8

Overview:
- Sequential radix-2 restoring divider that divides a 16-bit dividend by an 8-bit divisor.
- It is the inverse of the 8x8 multiplier datapath: it recovers an operand from a 16-bit product-width word.
- Valid/ready handshake on both input and output; one bit of quotient is resolved per clock.
- Used in the DFT test datapath to check multiplier results (Q*D+R == N).

Parameters:
- N_W, 16, dividend and quotient width.
- D_W, 8, divisor and remainder width; must satisfy D_W <= N_W.

Ports:
- CLK  in  1  single clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- IN_VALID  in  1  dividend and divisor present.
- IN_READY  out  1  block can accept an operation.
- DIVIDEND  in  N_W  numerator, unsigned.
- DIVISOR  in  D_W  denominator, unsigned.
- OUT_VALID  out  1  result registers hold a completed result.
- OUT_READY  in  1  consumer accepts the result.
- QUOTIENT  out  N_W  unsigned quotient.
- REMAINDER  out  D_W  unsigned remainder.
- DIV_BY_ZERO  out  1  flag qualified by OUT_VALID.

Behaviour:
- Reset (RST_N low, asynchronous): state IDLE; OUT_VALID=0; QUOTIENT=0; REMAINDER=0; DIV_BY_ZERO=0; iteration counter=0; IN_READY=1 after reset releases.
- IN_READY is 1 only in IDLE. It is combinational from the state register and does not depend on IN_VALID.
- States and transitions:
  - IDLE: on IN_VALID & IN_READY, capture the operands.
    - DIVISOR == 0: go to DONE with QUOTIENT={N_W{1}}, REMAINDER=DIVIDEND[D_W-1:0], DIV_BY_ZERO=1. OUT_VALID rises on the next cycle (latency 1).
    - Otherwise: load the dividend shift register with DIVIDEND, partial remainder (D_W+1 bits)=0, counter=N_W-1, and go to BUSY.
  - BUSY: each cycle performs one restoring step:
    - t = {rem[D_W-1:0], dividend_msb}; shift the dividend left.
    - If t >= {1'b0, divisor}: rem = t - divisor and q_bit = 1; else rem = t and q_bit = 0.
    - Shift q_bit into the quotient LSB.
    - After the step with counter==0, go to DONE; otherwise decrement the counter.
  - DONE: OUT_VALID=1. QUOTIENT, REMAINDER and DIV_BY_ZERO are registered and held stable while OUT_READY=0.
    - On OUT_READY=1, go to IDLE and drop OUT_VALID on the next edge.
- Latency:
  - Accept edge at cycle 0, then N_W BUSY cycles; OUT_VALID is high from cycle N_W+1 (17 for defaults).
  - Best-case throughput is one operation per N_W+2 cycles.
  - No accept in the same cycle as result hand-off.
- Width rules:
  - All arithmetic is unsigned.
  - The partial remainder is D_W+1 bits so the compare never overflows.
  - The final remainder is always < divisor and fits in D_W bits.
  - Invariant checked by the bench: QUOTIENT*DIVISOR + REMAINDER == DIVIDEND (for divisor != 0).
- Boundary conditions:
  - Dividend < divisor: quotient 0, remainder = dividend.
  - Divisor 1: quotient = dividend, remainder 0.
  - IN_VALID while BUSY or DONE is ignored; the operands are not sampled and the source must hold them.
  - Input changes during BUSY have no effect on the result (operands are captured at accept).
  - RST_N asserted mid-operation immediately aborts to IDLE and clears the outputs; no partial result is ever presented.
  - OUT_READY held high before completion: the result is consumed in the first DONE cycle, so OUT_VALID pulses for exactly one cycle.

Decomposition:
- Shared package div_pkg:
  - state enum {IDLE, BUSY, DONE};
  - width constants N_W_DEF=16 and D_W_DEF=8;
  - counter width localparam CNT_W = $clog2(N_W).
- One natural combinational sub-module: div_step. It takes the partial remainder, incoming bit and divisor, and outputs the next remainder and q_bit.
  - Keeps the top-level to the FSM and registers.
  - div_step can be tested standalone and reused for an unrolled variant.

Test Plan:
- 1000/7, OUT_READY=1 -> OUT_VALID at cycle 17 after accept, QUOTIENT=142, REMAINDER=6, DIV_BY_ZERO=0, one-cycle OUT_VALID pulse.
- 0xFFFF/0xFF and 0xFFFF/0x01 back-to-back -> Q=0x0101 R=0x00, then Q=0xFFFF R=0x00; IN_READY low from accept through hand-off.
- 0x0005/0x00 -> OUT_VALID one cycle after accept, Q=0xFFFF, R=0x05, DIV_BY_ZERO=1.
- 100/200 with OUT_READY=0 for 10 cycles after completion -> Q=0, R=100 held stable throughout; IN_VALID with 0x1234/0x10 is ignored until IDLE, then yields Q=0x0123 R=0x04.
- Pull RST_N low at BUSY cycle 8 of 1000/7 -> outputs 0, OUT_VALID 0, IN_READY 1 after release; a new 0x1234/0x10 then completes correctly.
- 2000 random dividend/divisor pairs with random OUT_READY stalls -> Q*D+R==N and R<D for every nonzero divisor.
